// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared width helpers and default timing for the button debouncer
package multi_debouncer_pkg;

    localparam int DEFAULT_TICK_DIV = 100000;

    // Bits needed to encode `numStates` distinct values; never less than one bit.
    function automatic int ctrWidth(input int numStates);
        return (numStates < 2) ? 1 : $clog2(numStates);
    endfunction

    localparam int DIV_W    = ctrWidth(DEFAULT_TICK_DIV);
    localparam int STABLE_W = ctrWidth(20 + 1);
    localparam int HOLD_W   = ctrWidth(500 + 1);

endpackage

// File: rtl/multi_debouncer_channel.sv
// rtl/multi_debouncer_channel.sv - one button: synchroniser, tick-sampled stability filter, edge pulses, long-press
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 20,
    parameter int HOLD_TICKS   = 500,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnRaw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall,
    output logic held
);

    localparam int SW = ctrWidth(STABLE_TICKS + 1);
    localparam int HW = ctrWidth(HOLD_TICKS + 1);

    logic          pressed;
    logic          syncA, syncB;
    logic [SW-1:0] cnt, cntNext;
    logic [HW-1:0] hc, hcNext;
    logic          levelNext;

    assign pressed = (ACTIVE_HIGH != 0) ? btnRaw : ~btnRaw;

    always_comb begin
        levelNext = level;
        cntNext   = cnt;
        hcNext    = hc;
        if (tick) begin
            if (syncB == level) begin
                cntNext = '0;
            end else if (cnt == SW'(STABLE_TICKS - 1)) begin
                levelNext = syncB;
                cntNext   = '0;
            end else begin
                cntNext = cnt + 1'b1;
            end
            if (level && (hc != HW'(HOLD_TICKS))) begin
                hcNext = hc + 1'b1;
            end
        end
        // Release clears the hold count in the same edge that drops level.
        if (!levelNext) begin
            hcNext = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
            cnt   <= '0;
            hc    <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            held  <= 1'b0;
        end else begin
            syncA <= pressed;
            syncB <= syncA;
            cnt   <= cntNext;
            hc    <= hcNext;
            level <= levelNext;
            rise  <= levelNext & ~level;
            fall  <= ~levelNext & level;
            held  <= (HOLD_TICKS != 0) && levelNext && (hcNext == HW'(HOLD_TICKS));
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel push-button conditioner sharing one sample-tick prescaler
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = 20,
    parameter int HOLD_TICKS   = 500,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] held
);

    localparam int DW = ctrWidth(TICK_DIV);

    logic [DW-1:0] divCnt;
    logic          tick;

    assign tick = (divCnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt <= '0;
        end else if (tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : gChannel
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .HOLD_TICKS  (HOLD_TICKS),
            .ACTIVE_HIGH (ACTIVE_HIGH)
        ) uChannel (
            .clk   (clk),
            .rst_n (rst_n),
            .btnRaw(btn_in[ch]),
            .tick  (tick),
            .level (level[ch]),
            .rise  (rise[ch]),
            .fall  (fall[ch]),
            .held  (held[ch])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - randomized and directed bench for multi_debouncer against a behavioural model
module tb_multi_debouncer;

    localparam int N  = 5;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int HT = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn, btnInv;
    logic [N-1:0] levelA, riseA, fallA, heldA;
    logic [N-1:0] levelB, riseB, fallB, heldB;
    logic [N-1:0] levelC, riseC, fallC, heldC;

    assign btnInv = ~btn;

    multi_debouncer #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT), .ACTIVE_HIGH(1)) dutA (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .level(levelA), .rise(riseA), .fall(fallA), .held(heldA));

    multi_debouncer #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(0), .ACTIVE_HIGH(1)) dutB (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .level(levelB), .rise(riseB), .fall(fallB), .held(heldB));

    multi_debouncer #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT), .ACTIVE_HIGH(0)) dutC (
        .clk(clk), .rst_n(rst_n), .btn_in(btnInv),
        .level(levelC), .rise(riseC), .fall(fallC), .held(heldC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: time measured in edges and ticks since reset.
    int           edges, tickIdx;
    int           pendStart [N];
    int           pressTick [N];
    logic         mTick;
    logic [N-1:0] d1, d2;
    logic [N-1:0] expLevel, expRise, expFall, expHeld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0; tickIdx = 0;
            d1 = '0; d2 = '0;
            expLevel = '0; expRise = '0; expFall = '0; expHeld = '0;
            for (int c = 0; c < N; c++) begin
                pendStart[c] = -1;
                pressTick[c] = 0;
            end
        end else begin
            mTick = ((edges % TD) == TD - 1);
            edges++;
            expRise = '0;
            expFall = '0;
            if (mTick) begin
                tickIdx++;
                for (int c = 0; c < N; c++) begin
                    if (d2[c] == expLevel[c]) begin
                        pendStart[c] = -1;
                    end else begin
                        if (pendStart[c] < 0) pendStart[c] = tickIdx;
                        if (tickIdx - pendStart[c] + 1 >= ST) begin
                            pendStart[c] = -1;
                            expLevel[c] = d2[c];
                            if (d2[c]) begin
                                expRise[c] = 1'b1;
                                pressTick[c] = tickIdx;
                            end else begin
                                expFall[c] = 1'b1;
                            end
                        end
                    end
                end
            end
            for (int c = 0; c < N; c++)
                expHeld[c] = expLevel[c] && (tickIdx - pressTick[c] >= HT);
            d2 = d1;
            d1 = btn;
        end
    end

    int           checks, errors;
    int           cyc;
    int           riseCnt [N];
    int           fallCnt [N];
    int           lastRise [N];
    int           heldRiseCyc [N];
    int           levelSeen [N];
    int           heldBSeen;
    logic [N-1:0] prevLevel, prevHeld;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        chk("levelA", levelA, expLevel);
        chk("riseA",  riseA,  expRise);
        chk("fallA",  fallA,  expFall);
        chk("heldA",  heldA,  expHeld);
        chk("levelB", levelB, expLevel);
        chk("riseB",  riseB,  expRise);
        chk("fallB",  fallB,  expFall);
        chk("heldB",  heldB,  '0);
        chk("levelC", levelC, expLevel);
        chk("riseC",  riseC,  expRise);
        chk("fallC",  fallC,  expFall);
        chk("heldC",  heldC,  expHeld);
    endtask

    task automatic clearStats();
        for (int c = 0; c < N; c++) begin
            riseCnt[c] = 0; fallCnt[c] = 0; lastRise[c] = -1;
            heldRiseCyc[c] = -1; levelSeen[c] = 0;
        end
        heldBSeen = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            checkModel();
            for (int c = 0; c < N; c++) begin
                if (riseA[c]) begin riseCnt[c]++; lastRise[c] = cyc; end
                if (fallA[c]) fallCnt[c]++;
                if (levelA[c]) levelSeen[c]++;
                if (heldA[c] && !prevHeld[c]) heldRiseCyc[c] = cyc;
                if (rst_n && prevLevel[c] && !levelA[c])
                    chk("dropPulse", {3'b000, fallA[c], heldA[c]}, 5'b00010);
            end
            if (heldB != '0) heldBSeen++;
            prevLevel = rst_n ? levelA : '0;
            prevHeld  = heldA;
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        prevLevel = '0; prevHeld = '0;
        clearStats();

        // Press held through reset
        rst_n = 1'b0;
        btn   = 5'b00001;
        step(3);
        chk("rstLevel", levelA | levelB | levelC, '0);
        chk("rstRise",  riseA | riseB | riseC,    '0);
        chk("rstFall",  fallA | fallB | fallC,    '0);
        chk("rstHeld",  heldA | heldB | heldC,    '0);
        rst_n = 1'b1;
        cyc = 0;
        clearStats();
        step(16);
        chkInt("rstRiseCnt", riseCnt[0], 1);
        chkInt("rstRiseWin", int'(lastRise[0] >= 12 && lastRise[0] <= 14), 1);
        chkInt("rstLevel0",  int'(levelA[0]), 1);

        // Bounce rejection on channel 0
        btn[0] = 1'b0;
        step(20);
        chkInt("bounceStart", int'(levelA[0]), 0);
        clearStats();
        for (int i = 0; i < 14; i++) begin
            btn[0] = ~btn[0];
            step(3);
        end
        btn[0] = 1'b1;
        step(24);
        chkInt("bounceRise",  riseCnt[0], 1);
        chkInt("bounceFall",  fallCnt[0], 0);
        chkInt("bounceLevel", int'(levelA[0]), 1);

        // Single-tick glitch on channel 2
        clearStats();
        btn[2] = 1'b1;
        step(4);
        btn[2] = 1'b0;
        step(20);
        chkInt("glitchLevel", levelSeen[2], 0);
        chkInt("glitchRise",  riseCnt[2], 0);
        chkInt("glitchFall",  fallCnt[2], 0);

        // Long press on channel 1
        clearStats();
        btn[1] = 1'b1;
        step(40);
        btn[1] = 1'b0;
        step(24);
        chkInt("longRise",   riseCnt[1], 1);
        chkInt("holdDelay",  heldRiseCyc[1] - lastRise[1], 20);
        chkInt("longFall",   fallCnt[1], 1);
        chkInt("holdOffB",   heldBSeen, 0);
        chkInt("longLevel",  int'(levelA[1]), 0);

        // Simultaneous presses on channels 1 and 3
        clearStats();
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        step(20);
        chkInt("multiRise1", riseCnt[1], 1);
        chkInt("multiRise3", riseCnt[3], 1);
        chkInt("multiSame",  lastRise[1] - lastRise[3], 0);
        chkInt("multiOther", riseCnt[0] + riseCnt[2] + riseCnt[4], 0);
        btn[1] = 1'b0;
        btn[3] = 1'b0;
        step(20);

        // Random stimulus, each channel occasionally flipping
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N; c++)
                btn[c] = btn[c] ^ ($urandom_range(0, 5) == 0);
            step(1);
        end
        btn = '0;
        step(20);

        // Async reset while channel 4 is held
        btn[4] = 1'b1;
        for (int i = 0; i < 60 && !heldA[4]; i++) step(1);
        chkInt("held4", int'(heldA[4]), 1);
        clearStats();
        #2;
        rst_n = 1'b0;
        #1;
        chk("asyncLevel", levelA | levelB | levelC, '0);
        chk("asyncPulse", riseA | fallA | riseB | fallB | riseC | fallC, '0);
        chk("asyncHeld",  heldA | heldC, '0);
        step(2);
        rst_n = 1'b1;
        cyc = 0;
        step(16);
        chkInt("reRiseCnt", riseCnt[4], 1);
        chkInt("reRiseWin", int'(lastRise[4] >= 12 && lastRise[4] <= 14), 1);
        chkInt("reNoFall",  fallCnt[4], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
